// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-requester data-memory arbiter.
// Lock support is compiled in only when DMEM_ARB_LOCK_EN is defined.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int LOCK_MAX   = 8;
    localparam int NUM_REQ    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arb_if.sv
// Requester A/B handshakes plus the data-memory port, bundled for dmem_arbiter.
// slave = arbiter view, master = requester/memory (environment) view.
interface dmem_arb_if import dmem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              a_req, a_we, a_lock;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt, a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req, b_we, b_lock;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt, b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] mem_read_addr, mem_write_addr;
    logic [DATA_W-1:0] mem_write_data, mem_read_data;
    logic              mem_write_enable;

    modport slave (
        input  a_req, a_we, a_lock, a_addr, a_wdata,
        input  b_req, b_we, b_lock, b_addr, b_wdata,
        input  mem_read_data,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output mem_read_addr, mem_write_addr, mem_write_data, mem_write_enable
    );

    modport master (
        output a_req, a_we, a_lock, a_addr, a_wdata,
        output b_req, b_we, b_lock, b_addr, b_wdata,
        output mem_read_data,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  mem_read_addr, mem_write_addr, mem_write_data, mem_write_enable
    );

endinterface

// File: rtl/dmem_arb_resp_reg.sv
// One-cycle read response register: rvalid pulses after a granted read,
// rdata holds the last returned word until the next read response.
module dmem_arb_resp_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o
);
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= load_i;
            if (load_i) rdata_q <= data_i;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between requesters A and B.
// Define DMEM_ARB_LOCK_EN to enable bus locking (OWN_A/OWN_B, 8-cycle cap).
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic       clk,
    input  logic       rst,
    dmem_arb_if.slave  bus
);
    logic                          rr_q;      // 1: B granted most recently
    logic                          gnt_a, gnt_b;
    logic [NUM_REQ-1:0]            load;
    logic [NUM_REQ-1:0]            rvalid;
    logic [NUM_REQ-1:0][DATA_W-1:0] rdata;

`ifdef DMEM_ARB_LOCK_EN
    arb_state_e state_q;
    logic [2:0] lock_cnt_q;
`else
    arb_state_e state_q;
    logic       unused_lock;
    assign state_q     = ST_IDLE;
    assign unused_lock = bus.a_lock | bus.b_lock;
`endif

    // Grants are masked during reset so nothing reaches memory while rst is high.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_OWN_A: gnt_a = bus.a_req;
                ST_OWN_B: gnt_b = bus.b_req;
                default: begin
                    if (bus.a_req && bus.b_req) begin
                        gnt_a = rr_q;
                        gnt_b = !rr_q;
                    end else begin
                        gnt_a = bus.a_req;
                        gnt_b = bus.b_req;
                    end
                end
            endcase
        end
    end

    // A force-released owner is also the last granted, so the pointer alone
    // hands the next contended cycle to the other requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q       <= 1'b1;
`ifdef DMEM_ARB_LOCK_EN
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
`endif
        end else begin
            if (gnt_a || gnt_b) rr_q <= gnt_b;
`ifdef DMEM_ARB_LOCK_EN
            unique case (state_q)
                ST_OWN_A: begin
                    if (!bus.a_req || !bus.a_lock || lock_cnt_q == 3'(LOCK_MAX - 1)) begin
                        state_q    <= ST_IDLE;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 3'd1;
                    end
                end
                ST_OWN_B: begin
                    if (!bus.b_req || !bus.b_lock || lock_cnt_q == 3'(LOCK_MAX - 1)) begin
                        state_q    <= ST_IDLE;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 3'd1;
                    end
                end
                default: begin
                    lock_cnt_q <= '0;
                    if (gnt_a && bus.a_lock) begin
                        state_q    <= ST_OWN_A;
                        lock_cnt_q <= 3'd1;
                    end else if (gnt_b && bus.b_lock) begin
                        state_q    <= ST_OWN_B;
                        lock_cnt_q <= 3'd1;
                    end
                end
            endcase
`endif
        end
    end

    always_comb begin
        bus.mem_read_addr    = '0;
        bus.mem_write_addr   = '0;
        bus.mem_write_data   = '0;
        bus.mem_write_enable = 1'b0;
        if (gnt_a) begin
            bus.mem_read_addr    = bus.a_addr;
            bus.mem_write_addr   = bus.a_addr;
            bus.mem_write_data   = bus.a_wdata;
            bus.mem_write_enable = bus.a_we;
        end else if (gnt_b) begin
            bus.mem_read_addr    = bus.b_addr;
            bus.mem_write_addr   = bus.b_addr;
            bus.mem_write_data   = bus.b_wdata;
            bus.mem_write_enable = bus.b_we;
        end
    end

    assign load = {gnt_b & ~bus.b_we, gnt_a & ~bus.a_we};

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_resp
        dmem_arb_resp_reg #(.DATA_W(DATA_W)) u_resp (
            .clk      (clk),
            .rst      (rst),
            .load_i   (load[g]),
            .data_i   (bus.mem_read_data),
            .rvalid_o (rvalid[g]),
            .rdata_o  (rdata[g])
        );
    end

    assign bus.a_gnt    = gnt_a;
    assign bus.b_gnt    = gnt_b;
    assign bus.a_rvalid = rvalid[0];
    assign bus.a_rdata  = rdata[0];
    assign bus.b_rvalid = rvalid[1];
    assign bus.b_rdata  = rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle vector table, read-response scoreboard,
// and hand-written reset/lock sequences. Lock checks follow DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arb_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Data memory: combinational read, synchronous write, preloaded with i*4.
    logic [31:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = 32'(i * 4);
    always @(posedge clk) if (bus.mem_write_enable) mem[bus.mem_write_addr] <= bus.mem_write_data;
    assign bus.mem_read_data = mem[bus.mem_read_addr];

    typedef struct {
        logic        ar, aw, al;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        br, bw, bl;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ega, egb;
        logic [31:0] erd;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] last_a, last_b;

    function automatic vec_t mk(input logic ar, aw, al, input logic [4:0] aa, input logic [31:0] ad,
                                input logic br, bw, bl, input logic [4:0] ba, input logic [31:0] bd,
                                input logic ega, egb, input logic [31:0] erd);
        vec_t v;
        v.ar = ar; v.aw = aw; v.al = al; v.aa = aa; v.ad = ad;
        v.br = br; v.bw = bw; v.bl = bl; v.ba = ba; v.bd = bd;
        v.ega = ega; v.egb = egb; v.erd = erd;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.a_req = v.ar; bus.a_we = v.aw; bus.a_lock = v.al; bus.a_addr = v.aa; bus.a_wdata = v.ad;
        bus.b_req = v.br; bus.b_we = v.bw; bus.b_lock = v.bl; bus.b_addr = v.ba; bus.b_wdata = v.bd;
    endtask

    task automatic check_resp(input string tag);
        if (qa.size() > 0) begin
            last_a = qa.pop_front();
            chk({tag, " a_rvalid"}, 32'(bus.a_rvalid), 32'd1);
        end else begin
            chk({tag, " a_rvalid"}, 32'(bus.a_rvalid), 32'd0);
        end
        chk({tag, " a_rdata"}, bus.a_rdata, last_a);
        if (qb.size() > 0) begin
            last_b = qb.pop_front();
            chk({tag, " b_rvalid"}, 32'(bus.b_rvalid), 32'd1);
        end else begin
            chk({tag, " b_rvalid"}, 32'(bus.b_rvalid), 32'd0);
        end
        chk({tag, " b_rdata"}, bus.b_rdata, last_b);
    endtask

    // One clock: drive, check grant and memory outputs, then the response.
    task automatic apply(input vec_t v, input string tag);
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        ew;
        @(negedge clk);
        drive(v);
        #1;
        ea = v.ega ? v.aa : v.egb ? v.ba : 5'd0;
        ed = v.ega ? v.ad : v.egb ? v.bd : 32'd0;
        ew = v.ega ? v.aw : v.egb ? v.bw : 1'b0;
        chk({tag, " a_gnt"}, 32'(bus.a_gnt), 32'(v.ega));
        chk({tag, " b_gnt"}, 32'(bus.b_gnt), 32'(v.egb));
        chk({tag, " mem_we"}, 32'(bus.mem_write_enable), 32'(ew));
        chk({tag, " mem_raddr"}, 32'(bus.mem_read_addr), 32'(ea));
        chk({tag, " mem_waddr"}, 32'(bus.mem_write_addr), 32'(ea));
        chk({tag, " mem_wdata"}, bus.mem_write_data, ed);
        if (v.ega && !v.aw) qa.push_back(v.erd);
        if (v.egb && !v.bw) qb.push_back(v.erd);
        @(posedge clk);
        #1;
        check_resp(tag);
    endtask

    // Requests held high through reset to show grants are suppressed.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(mk(1, 1, 1, 5'd1, 32'h55, 1, 0, 1, 5'd2, 32'h0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("rst a_gnt", 32'(bus.a_gnt), 32'd0);
        chk("rst b_gnt", 32'(bus.b_gnt), 32'd0);
        chk("rst mem_we", 32'(bus.mem_write_enable), 32'd0);
        chk("rst a_rvalid", 32'(bus.a_rvalid), 32'd0);
        chk("rst b_rvalid", 32'(bus.b_rvalid), 32'd0);
        chk("rst a_rdata", bus.a_rdata, 32'd0);
        chk("rst b_rdata", bus.b_rdata, 32'd0);
        @(negedge clk);
        drive(mk(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, 0, 0));
        rst = 1'b0;
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
    endtask

    vec_t tbl[9];
    vec_t idle_v;

    initial begin
        rst = 1'b1;
        drive(mk(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, 0, 0));
        idle_v = mk(0, 0, 0, 5'd0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, 0, 0);

        // Single read straight out of reset: same-cycle grant, data next cycle.
        do_reset();
        apply(mk(1, 0, 0, 5'd5, 32'h0, 0, 0, 0, 5'd0, 32'h0, 1, 0, 32'd20), "rd5");
        apply(idle_v, "rd5 hold");

        //           ar aw al aa     ad            br bw bl ba     bd             ga gb erd
        tbl[0] = mk(1, 0, 0, 5'd1,  32'h0,        1, 0, 0, 5'd2,  32'h0,         1, 0, 32'd4);
        tbl[1] = mk(1, 0, 0, 5'd1,  32'h0,        1, 0, 0, 5'd2,  32'h0,         0, 1, 32'd8);
        tbl[2] = mk(1, 0, 0, 5'd1,  32'h0,        1, 0, 0, 5'd2,  32'h0,         1, 0, 32'd4);
        tbl[3] = mk(1, 0, 0, 5'd1,  32'h0,        1, 0, 0, 5'd2,  32'h0,         0, 1, 32'd8);
        tbl[4] = mk(0, 0, 0, 5'd0,  32'h0,        1, 1, 0, 5'd3,  32'hDEADBEEF,  0, 1, 32'd0);
        tbl[5] = mk(1, 0, 0, 5'd3,  32'h0,        0, 0, 0, 5'd0,  32'h0,         1, 0, 32'hDEADBEEF);
        tbl[6] = mk(1, 1, 0, 5'd7,  32'h1234,     1, 0, 0, 5'd7,  32'h0,         0, 1, 32'd28);
        tbl[7] = mk(0, 0, 0, 5'd0,  32'h0,        0, 0, 0, 5'd0,  32'h0,         0, 0, 32'd0);
        tbl[8] = mk(0, 0, 0, 5'd0,  32'h0,        1, 0, 0, 5'd31, 32'h0,         0, 1, 32'd124);

        do_reset();
        for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i));
        apply(idle_v, "vec idle");

        // Reset pulsed mid read grant: the aborted read never responds.
        do_reset();
        @(negedge clk);
        drive(mk(1, 0, 0, 5'd5, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, 0, 0));
        #1;
        chk("abort a_gnt pre", 32'(bus.a_gnt), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort a_gnt in rst", 32'(bus.a_gnt), 32'd0);
        @(posedge clk);
        #1;
        chk("abort a_rvalid in rst", 32'(bus.a_rvalid), 32'd0);
        @(negedge clk);
        drive(idle_v);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort a_rvalid after", 32'(bus.a_rvalid), 32'd0);
        chk("abort a_rdata after", bus.a_rdata, 32'd0);
        apply(mk(1, 0, 0, 5'd2, 32'h0, 1, 0, 0, 5'd4, 32'h0, 1, 0, 32'd8), "abort ptr");

`ifdef DMEM_ARB_LOCK_EN
        // A locks for 10 cycles against B: 8 grants, B once, then A again.
        do_reset();
        for (int i = 0; i < 10; i++)
            apply(mk(1, 0, 1, 5'd0, 32'h0, 1, 0, 0, 5'd1, 32'h0,
                     (i < 8) || (i == 9), i == 8, (i == 8) ? 32'd4 : 32'd0),
                  $sformatf("lock%0d", i));
        apply(idle_v, "lock drop");
        apply(mk(0, 0, 0, 5'd0, 32'h0, 1, 0, 0, 5'd6, 32'h0, 0, 1, 32'd24), "lock idle b");
`else
        // Lock is ignored: contention still alternates every cycle.
        do_reset();
        for (int i = 0; i < 4; i++)
            apply(mk(1, 0, 1, 5'd0, 32'h0, 1, 0, 0, 5'd1, 32'h0,
                     (i % 2) == 0, (i % 2) == 1, ((i % 2) == 1) ? 32'd4 : 32'd0),
                  $sformatf("nolock%0d", i));
`endif
        apply(idle_v, "final idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
